// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file write port between the pipeline writeback
//   stage (A, priority, no backpressure) and a long-latency unit (B,
//   valid/ready, results buffered in a small FIFO). Reports per-source
//   "pending write" status for issue stalls and forces a writeback bubble
//   (stall_a) when the FIFO head has been blocked for MAX_WAIT cycles.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   a_valid, a_addr, a_data        pipeline writeback request
//   b_valid, b_ready, b_addr, b_data  long-latency result handshake
//   rf_write, rf_addr, rf_data     register file write port
//   stall_a                        pipeline must not write back this cycle
//   rs1_addr/rs2_addr -> rs1_busy/rs2_busy  pending-write query
module regfile_wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        rf_write,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        stall_a,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [4:0]        mem_addr [DEPTH];
  logic [31:0]       mem_data [DEPTH];
  logic [DEPTH-1:0]  entry_vld;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;

  logic fifo_empty;
  logic a_win;
  logic pop;
  logic push;

  assign fifo_empty = (count == '0);
  assign stall_a    = (wait_cnt == WAIT_MAX);
  // Registered count only, so B never sees a path from the grant logic.
  assign b_ready    = (count != FULL_CNT);
  assign a_win      = !stall_a && a_valid && (a_addr != 5'd0);
  assign pop        = !a_win && !fifo_empty;
  // Writes to x0 complete the handshake but are dropped.
  assign push       = b_valid && b_ready && (b_addr != 5'd0);

  always_comb begin
    rf_write = 1'b0;
    rf_addr  = 5'd0;
    rf_data  = 32'd0;
    if (a_win) begin
      rf_write = 1'b1;
      rf_addr  = a_addr;
      rf_data  = a_data;
    end else if (pop) begin
      rf_write = 1'b1;
      rf_addr  = mem_addr[rd_ptr];
      rf_data  = mem_data[rd_ptr];
    end
  end

  // Busy covers every stored entry, including the one popping this cycle.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (mem_addr[i] == rs1_addr)) rs1_busy = 1'b1;
      if (entry_vld[i] && (mem_addr[i] == rs2_addr)) rs2_busy = 1'b1;
    end
    if (rs1_addr == 5'd0) rs1_busy = 1'b0;
    if (rs2_addr == 5'd0) rs2_busy = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      entry_vld <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      // Push and pop never target the same slot: pop needs count>0 and
      // push needs count<DEPTH, so equal pointers imply only one of them.
      if (pop)  entry_vld[rd_ptr] <= 1'b0;
      if (push) entry_vld[wr_ptr] <= 1'b1;

      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      if (fifo_empty || pop) wait_cnt <= '0;
      else if (!stall_a)     wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Payload storage needs no reset; entry_vld qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= b_addr;
      mem_data[wr_ptr] <= b_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed scenarios plus randomized traffic, checked cycle by cycle
//   against a queue-based reference model of the arbiter.
module tb_regfile_wb_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall_a;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .rf_write (rf_write),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .stall_a  (stall_a),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending B results in arrival order plus the count of
  // consecutive cycles the oldest one has been denied the port.
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   blocked = 0;

  function automatic bit model_stall();
    return blocked == MAX_WAIT;
  endfunction

  function automatic bit pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].addr == r) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive, check the combinational view, advance the model.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit          stl, a_takes, head_goes, rdy;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    rs1_addr = r1; rs2_addr = r2;
    #1;
    stl       = model_stall();
    rdy       = q.size() < DEPTH;
    a_takes   = !stl && av && (aa != 5'd0);
    head_goes = !a_takes && (q.size() > 0);
    e_wr = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    if (a_takes) begin
      e_wr = 1'b1; e_addr = aa; e_data = ad;
    end else if (head_goes) begin
      e_wr = 1'b1; e_addr = q[0].addr; e_data = q[0].data;
    end
    if (av && stl)            check_val("a_valid_in_stall", 32'(av), 32'd0);
    if (av && aa != 5'd0)     check_val("waw_contract", 32'(pending(aa)), 32'd0);
    check_val("stall_a",  32'(stall_a),  32'(stl));
    check_val("b_ready",  32'(b_ready),  32'(rdy));
    check_val("rf_write", 32'(rf_write), 32'(e_wr));
    check_val("rf_addr",  32'(rf_addr),  32'(e_addr));
    check_val("rf_data",  rf_data,       e_data);
    check_val("rs1_busy", 32'(rs1_busy), 32'(pending(r1)));
    check_val("rs2_busy", 32'(rs2_busy), 32'(pending(r2)));
    if (q.size() == 0 || head_goes) blocked = 0;
    else if (blocked < MAX_WAIT)    blocked++;
    if (head_goes) void'(q.pop_front());
    if (bv && rdy && ba != 5'd0) q.push_back('{addr: ba, data: bd});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_rf_write"}, 32'(rf_write), 32'd0);
    check_val({pfx, "_rf_addr"},  32'(rf_addr),  32'd0);
    check_val({pfx, "_rf_data"},  rf_data,       32'd0);
    check_val({pfx, "_stall_a"},  32'(stall_a),  32'd0);
    check_val({pfx, "_b_ready"},  32'(b_ready),  32'd1);
    check_val({pfx, "_rs1_busy"}, 32'(rs1_busy), 32'd0);
    check_val({pfx, "_rs2_busy"}, 32'(rs2_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_stall;
    int cyc;
    int a_pct;
    logic [4:0] aa;

    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    rs1_addr = 5'd7; rs2_addr = 5'd10;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Only B: push x7 and watch it become busy, get written, then clear.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0);
    check_val("b_only_busy", 32'(rs1_busy), 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    check_val("b_only_after", 32'(rs1_busy), 32'd0);

    // Contention: A writes x3 every cycle while B queues x10..x13.
    first_stall = -1;
    cyc = 0;
    while (cyc < 20) begin
      if (stall_a && first_stall < 0) first_stall = cyc;
      step(!model_stall(), 5'd3, 32'h3000_0000 + 32'(cyc),
           cyc < 4, 5'(10 + cyc), 32'hB000_0000 + 32'(cyc), 5'd10, 5'd13);
      cyc++;
      if (first_stall >= 0) break;
    end
    check_val("stall_cycle", 32'(first_stall), 32'd9);
    check_val("stall_cleared", 32'(stall_a), 32'd0);

    // Full-ish with B held: pop each cycle, push/pop together, order across wrap.
    for (int i = 0; i < 10; i++)
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'(14 + i), 32'hC000_0000 + 32'(i), 5'(11 + i), 5'd0);
    idle(6);

    // x0 handling on both requesters.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
    check_val("x0_b_drop", 32'(rf_write), 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0909_0909, 5'd9, 5'd0);
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    idle(2);

    // Async reset with three queued entries and stall_a asserted.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd5, 32'h5, 1'b1, 5'(20 + i), 32'hD000_0000 + 32'(i), 5'd0, 5'd0);
    cyc = 0;
    while (!model_stall() && cyc < 20) begin
      step(1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 32'd0, 5'd20, 5'd22);
      cyc++;
    end
    check_val("pre_reset_stall", 32'(stall_a), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;
    rs1_addr = 5'd20; rs2_addr = 5'd22;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    #2;
    rst_n = 1'b1;
    q.delete();
    blocked = 0;
    @(posedge clk);
    #1;
    idle(4);

    // Randomized traffic with varying A density to reach full and stall.
    a_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) a_pct = $urandom_range(0, 100);
      aa = 5'($urandom_range(0, 31));
      if (pending(aa)) aa = 5'd0;
      step(!model_stall() && ($urandom_range(0, 99) < a_pct), aa, $urandom,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom,
           (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[0].addr : 5'($urandom_range(0, 31)),
           (q.size() > 0) ? q[q.size()-1].addr : 5'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
